mem_port_arbiter: RTL and testbench



---
 rtl/arb_pkg.sv | 13 +
 rtl/mem_port_arbiter_if.sv | 30 +++
 rtl/arb_rr_pick.sv | 33 +++
 rtl/mem_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the two-master memory port arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

    localparam logic ARB_M_CPU = 1'b0;
    localparam logic ARB_M_AUX = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles both master request ports and the memory-side port of mem_port_arbiter.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 14
) ();
    logic [1:0]                 m_req;
    logic [1:0]                 m_lock;
    logic [1:0]                 m_we;
    logic [1:0][ADDR_WIDTH-1:0] m_addr;
    logic [1:0][31:0]           m_wdata;
    logic [1:0][3:0]            m_be;
    logic [1:0]                 m_gnt;
    logic [1:0]                 m_rvalid;
    logic [31:0]                m_rdata;
    logic                       mem_en;
    logic                       mem_we;
    logic [ADDR_WIDTH-1:0]      mem_addr;
    logic [31:0]                mem_wdata;
    logic [3:0]                 mem_be;
    logic [31:0]                mem_rdata;

    modport master (
        output m_req, m_lock, m_we, m_addr, m_wdata, m_be, mem_rdata,
        input  m_gnt, m_rvalid, m_rdata, mem_en, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport slave (
        input  m_req, m_lock, m_we, m_addr, m_wdata, m_be, mem_rdata,
        output m_gnt, m_rvalid, m_rdata, mem_en, mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/arb_rr_pick.sv
// Combinational 2-way winner select. ARB_ROUND_ROBIN_EN selects round-robin;
// otherwise master 0 wins contests unless a forced release handed priority over.
module arb_rr_pick
    import arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       hold,
    output logic       winner,
    output logic       any_req
);

`ifdef ARB_ROUND_ROBIN_EN
    logic unused_hold_s;
    assign unused_hold_s = hold;
`endif

    // Winner select; a contest falls back to the configured policy.
    always_comb begin
        any_req = |req;
        case (req)
            2'b01:   winner = ARB_M_CPU;
            2'b10:   winner = ARB_M_AUX;
`ifdef ARB_ROUND_ROBIN_EN
            2'b11:   winner = ~last;
`else
            2'b11:   winner = hold ? ~last : ARB_M_CPU;
`endif
            default: winner = ARB_M_CPU;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for one single-port synchronous memory with bounded burst locking.
// Build option: ARB_ROUND_ROBIN_EN (round-robin contests; fixed priority when undefined).
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 14,
    parameter int MAX_LOCK   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.slave  bus
);

    localparam int            CW       = $clog2(MAX_LOCK + 1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_LOCK);

    arb_state_t      state_q, state_d;
    logic            last_q, last_d;
    logic            hold_q, hold_d;
    logic [CW-1:0]   lock_cnt_q, lock_cnt_d;
    logic            rd_pending_q, rd_pending_d;
    logic            rd_owner_q, rd_owner_d;

    logic            pick_win_s;
    logic            pick_any_s;
    logic [1:0]      gnt_s;
    logic [1:0]      gnt_out_s;
    logic            win_s;
    logic [ADDR_WIDTH-1:0] addr_s;

    arb_rr_pick u_pick (
        .req     (bus.m_req),
        .last    (last_q),
        .hold    (hold_q),
        .winner  (pick_win_s),
        .any_req (pick_any_s)
    );

    // Next-state, grant and lock-count logic.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        hold_d     = hold_q;
        lock_cnt_d = lock_cnt_q;
        gnt_s      = 2'b00;
        win_s      = ARB_M_CPU;
        case (state_q)
            IDLE: begin
                if (pick_any_s) begin
                    win_s             = pick_win_s;
                    gnt_s[pick_win_s] = 1'b1;
                    last_d            = pick_win_s;
                    if (&bus.m_req) begin
                        hold_d = 1'b0;
                    end else begin
                        hold_d = hold_q;
                    end
                    if (bus.m_lock[pick_win_s]) begin
                        state_d    = pick_win_s ? LOCK1 : LOCK0;
                        lock_cnt_d = CNT_ONE;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            LOCK0, LOCK1: begin
                win_s = (state_q == LOCK1) ? ARB_M_AUX : ARB_M_CPU;
                if (bus.m_req[win_s]) begin
                    gnt_s[win_s] = 1'b1;
                    last_d       = win_s;
                end else begin
                    gnt_s = 2'b00;
                end
                if (bus.m_req[win_s] && bus.m_lock[win_s]) begin
                    // Forced release leaves last = owner so the other master wins next.
                    if ((lock_cnt_q + CNT_ONE) == CNT_MAX) begin
                        state_d    = IDLE;
                        lock_cnt_d = CNT_ZERO;
                        hold_d     = 1'b1;
                    end else begin
                        lock_cnt_d = lock_cnt_q + CNT_ONE;
                    end
                end else begin
                    state_d    = IDLE;
                    lock_cnt_d = CNT_ZERO;
                end
            end
            default: begin
                state_d    = IDLE;
                lock_cnt_d = CNT_ZERO;
            end
        endcase
        rd_pending_d = (|gnt_s) & ~bus.m_we[win_s];
        rd_owner_d   = win_s;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_q       <= ARB_M_AUX;
            hold_q       <= 1'b0;
            lock_cnt_q   <= CNT_ZERO;
            rd_pending_q <= 1'b0;
            rd_owner_q   <= ARB_M_CPU;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            hold_q       <= hold_d;
            lock_cnt_q   <= lock_cnt_d;
            rd_pending_q <= rd_pending_d;
            rd_owner_q   <= rd_owner_d;
        end
    end

    // Memory-side and master-side output drive; everything is quiet while reset is low.
    always_comb begin
        gnt_out_s     = rst_n ? gnt_s : 2'b00;
        addr_s        = bus.m_addr[win_s];
        bus.m_gnt     = gnt_out_s;
        bus.mem_en    = |gnt_out_s;
        bus.m_rvalid  = 2'b00;
        bus.m_rdata   = 32'h0000_0000;
        if (|gnt_out_s) begin
            bus.mem_we    = bus.m_we[win_s];
            bus.mem_addr  = addr_s;
            bus.mem_wdata = bus.m_wdata[win_s];
            bus.mem_be    = bus.m_be[win_s];
        end else begin
            bus.mem_we    = 1'b0;
            bus.mem_addr  = {ADDR_WIDTH{1'b0}};
            bus.mem_wdata = 32'h0000_0000;
            bus.mem_be    = 4'h0;
        end
        if (rst_n && rd_pending_q) begin
            bus.m_rvalid[rd_owner_q] = 1'b1;
            bus.m_rdata              = bus.mem_rdata;
        end else begin
            bus.m_rdata = 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter against a behavioural arbitration model.
module tb_mem_port_arbiter;

    localparam int AW = 14;
    localparam int ML = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

    mem_port_arbiter #(.ADDR_WIDTH(AW), .MAX_LOCK(ML)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input int idx);
        if (idx == 16) return 32'hDEAD_BEEF;
        return 32'hA5C3_0000 + idx;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // Memory behind the DUT: 32 words, upper address bits alias.
    bit [31:0] phys_mem [0:31];
    bit        phys_wr  [0:31];
    always @(posedge clk) begin
        int idx;
        logic [31:0] cur;
        idx = int'(bus.mem_addr[4:0]);
        cur = phys_wr[idx] ? phys_mem[idx] : init_word(idx);
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                phys_mem[idx] <= merge(cur, bus.mem_wdata, bus.mem_be);
                phys_wr[idx]  <= 1'b1;
            end else begin
                bus.mem_rdata <= cur;
            end
        end
    end

    // Reference memory and arbitration model.
    bit [31:0] ref_mem [0:31];
    bit        ref_wr  [0:31];
    int owner;        // -1 when nobody holds the port
    int run;          // grants taken in the current locked burst
    int prev;         // most recent grant winner
    bit rel_pending;  // a forced release handed contest priority away from prev

    typedef struct { int who; logic [31:0] data; int due; } rd_t;
    rd_t sb[$];

    function automatic void model_reset();
        owner = -1; run = 0; prev = 1; rel_pending = 1'b0;
    endfunction

    function automatic int model_step(input logic [1:0] req, input logic [1:0] lock);
        int w;
        if (owner < 0) begin
            if (req == 2'b00) w = -1;
            else if (req == 2'b01) w = 0;
            else if (req == 2'b10) w = 1;
            else begin
`ifdef ARB_ROUND_ROBIN_EN
                w = 1 - prev;
`else
                w = rel_pending ? 1 - prev : 0;
`endif
                rel_pending = 1'b0;
            end
            if (w >= 0) begin
                prev = w;
                if (lock[w]) begin owner = w; run = 1; end
            end
        end else begin
            w = req[owner] ? owner : -1;
            if (w >= 0) prev = w;
            if (req[owner] && lock[owner]) begin
                run++;
                if (run == ML) begin owner = -1; run = 0; rel_pending = 1'b1; end
            end else begin
                owner = -1; run = 0;
            end
        end
        return w;
    endfunction

    task automatic apply(input logic rn, input logic [1:0] req, input logic [1:0] lock, input logic [1:0] we,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1, input logic [3:0] b0, input logic [3:0] b1);
        int w;
        int idx;
        logic [1:0]  eg;
        logic [AW+37:0] emem, gmem;
        logic [AW-1:0] ea [2];
        logic [31:0]   ed [2];
        logic [3:0]    eb [2];
        ea[0] = a0; ea[1] = a1; ed[0] = d0; ed[1] = d1; eb[0] = b0; eb[1] = b1;
        @(posedge clk);
        #2;
        rst_n          = rn;
        bus.m_req      = req;
        bus.m_lock     = lock;
        bus.m_we       = we;
        bus.m_addr[0]  = a0;  bus.m_addr[1]  = a1;
        bus.m_wdata[0] = d0;  bus.m_wdata[1] = d1;
        bus.m_be[0]    = b0;  bus.m_be[1]    = b1;
        #1;
        if (!rn) begin
            w = -1;
            sb.delete();
            model_reset();
        end else begin
            w = model_step(req, lock);
        end
        eg = 2'b00;
        emem = '0;
        if (w >= 0) begin
            eg[w] = 1'b1;
            emem  = {1'b1, we[w], ea[w], ed[w], eb[w]};
        end
        gmem = {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be};
        n_vec++;
        if (bus.m_gnt !== eg) begin
            n_err++;
            $display("FAIL gnt cyc=%0d got=%b want=%b", cyc, bus.m_gnt, eg);
        end
        n_vec++;
        if (gmem !== emem) begin
            n_err++;
            $display("FAIL membus cyc=%0d got=%h want=%h", cyc, gmem, emem);
        end
        if (!rn) begin
            n_vec++;
            if (bus.m_rvalid !== 2'b00 || bus.m_rdata !== 32'h0) begin
                n_err++;
                $display("FAIL reset_out cyc=%0d rvalid=%b rdata=%h want 0", cyc, bus.m_rvalid, bus.m_rdata);
            end
        end
        if (w >= 0) begin
            idx = int'(ea[w][4:0]);
            if (we[w]) begin
                ref_mem[idx] = merge(ref_wr[idx] ? ref_mem[idx] : init_word(idx), ed[w], eb[w]);
                ref_wr[idx]  = 1'b1;
            end else begin
                sb.push_back('{w, ref_wr[idx] ? ref_mem[idx] : init_word(idx), cyc + 1});
            end
        end
    endtask

    // Read-return monitor: pops the scoreboard whenever a read result is due or shown.
    initial begin
        rd_t e;
        logic [1:0] ev;
        forever begin
            @(negedge clk);
            if (bus.m_rvalid !== 2'b00) begin
                n_vec++;
                if (sb.size() > 0 && sb[0].due == cyc) begin
                    e = sb.pop_front();
                    ev = 2'b00; ev[e.who] = 1'b1;
                    if (bus.m_rvalid !== ev || bus.m_rdata !== e.data) begin
                        n_err++;
                        $display("FAIL rdata cyc=%0d got rvalid=%b data=%h want rvalid=%b data=%h",
                                 cyc, bus.m_rvalid, bus.m_rdata, ev, e.data);
                    end
                end else begin
                    n_err++;
                    $display("FAIL spurious_rvalid cyc=%0d got=%b want=00", cyc, bus.m_rvalid);
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                n_vec++;
                n_err++;
                $display("FAIL missing_rvalid cyc=%0d got=00 want master %0d data=%h", cyc, e.who, e.data);
            end
        end
    end

    initial begin
        logic [1:0] rq, lk, we;
        logic [AW-1:0] a0, a1;
        model_reset();
        rst_n = 1'b0;
        bus.m_req = 2'b00; bus.m_lock = 2'b00; bus.m_we = 2'b00;
        bus.m_addr = '0; bus.m_wdata = '0; bus.m_be = '0;
        for (int i = 0; i < 3; i++)
            apply(1'b0, 2'b00, 2'b00, 2'b00, 14'h0, 14'h0, 32'h0, 32'h0, 4'h0, 4'h0);
        // single read of 0x10 by master 0
        apply(1'b1, 2'b01, 2'b00, 2'b00, 14'h0010, 14'h0, 32'h0, 32'h0, 4'hF, 4'h0);
        apply(1'b1, 2'b00, 2'b00, 2'b00, 14'h0, 14'h0, 32'h0, 32'h0, 4'h0, 4'h0);
        // contested, no lock
        for (int i = 0; i < 4; i++)
            apply(1'b1, 2'b11, 2'b00, 2'b00, 14'h0003, 14'h0004, 32'h0, 32'h0, 4'hF, 4'hF);
        // master 1 locks with master 0 contending: forced release after ML grants
        apply(1'b1, 2'b10, 2'b10, 2'b00, 14'h0, 14'h0005, 32'h0, 32'h0, 4'h0, 4'hF);
        for (int i = 0; i < 5; i++)
            apply(1'b1, 2'b11, 2'b10, 2'b00, 14'h0006, 14'h0007, 32'h0, 32'h0, 4'hF, 4'hF);
        // master 0 locks, drops lock on its third access
        apply(1'b1, 2'b11, 2'b01, 2'b00, 14'h0008, 14'h0009, 32'h0, 32'h0, 4'hF, 4'hF);
        apply(1'b1, 2'b11, 2'b01, 2'b00, 14'h0008, 14'h0009, 32'h0, 32'h0, 4'hF, 4'hF);
        apply(1'b1, 2'b11, 2'b00, 2'b00, 14'h0008, 14'h0009, 32'h0, 32'h0, 4'hF, 4'hF);
        apply(1'b1, 2'b11, 2'b00, 2'b00, 14'h0008, 14'h0009, 32'h0, 32'h0, 4'hF, 4'hF);
        // m0 read then m1 write back-to-back
        apply(1'b1, 2'b01, 2'b00, 2'b00, 14'h0010, 14'h0, 32'h0, 32'h0, 4'hF, 4'h0);
        apply(1'b1, 2'b10, 2'b00, 2'b10, 14'h0, 14'h0011, 32'h0, 32'h1234_5678, 4'h0, 4'h5);
        // reset right after a read grant, then a contest
        apply(1'b1, 2'b01, 2'b00, 2'b00, 14'h0011, 14'h0, 32'h0, 32'h0, 4'hF, 4'h0);
        apply(1'b0, 2'b11, 2'b00, 2'b00, 14'h0011, 14'h0, 32'h0, 32'h0, 4'hF, 4'h0);
        apply(1'b1, 2'b11, 2'b00, 2'b00, 14'h0012, 14'h0013, 32'h0, 32'h0, 4'hF, 4'hF);
        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            rq = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
            lk = 2'($urandom_range(0, 3));
            we = 2'($urandom_range(0, 3));
            a0 = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 31)) : AW'($urandom);
            a1 = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 31)) : AW'($urandom);
            apply(($urandom_range(0, 99) != 0), rq, lk, we, a0, a1, $urandom, $urandom,
                  4'($urandom), 4'($urandom));
        end
        for (int i = 0; i < 3; i++)
            apply(1'b1, 2'b00, 2'b00, 2'b00, 14'h0, 14'h0, 32'h0, 32'h0, 4'h0, 4'h0);
        @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
